// File: rtl/luma_sobel_edge_pkg.sv
// Shared constants and helpers for the luma Sobel edge detector.
//   LAT     : clocks from a pixel entering to its edge value leaving
//   MAG_W   : width of the signed gradients and the unsigned magnitude
//   SAT_MAX : largest 8-bit output value
//   absMag  : magnitude of a signed gradient
//   sat8    : clamps a magnitude to the 8-bit output range
package luma_sobel_edge_pkg;

    localparam int         LAT     = 4;
    localparam int         MAG_W   = 11;
    localparam logic [7:0] SAT_MAX = 8'd255;

    // The negation is safe because gradients never reach -1024.
    function automatic logic [MAG_W-1:0] absMag(input logic signed [MAG_W-1:0] v);
        logic [MAG_W-1:0] r;
        r = v[MAG_W-1] ? -v : v;
        return r;
    endfunction

    function automatic logic [7:0] sat8(input logic [MAG_W-1:0] m);
        return (m > {{(MAG_W-8){1'b0}}, SAT_MAX}) ? SAT_MAX : m[7:0];
    endfunction

endpackage

// File: rtl/luma_sobel_edge_line_window.sv
// Line buffering and 3x3 window for the Sobel detector.
// Ports:
//   clk, rst_b : pixel clock, asynchronous active-low reset
//   vs_i, de_i : vertical sync and data enable of the incoming stream
//   y_i        : incoming luma
//   taps_o     : window, taps_o[row][col]; row 0 oldest line, col 0 oldest pixel
//   border_o   : window is incomplete or invalid, its edge value must be 0
// Stage 1 updates the counters and reads/writes the line RAMs; stage 2 shifts
// the window, so taps_o and border_o lag the input by two clocks.
module sobel_line_window
    import luma_sobel_edge_pkg::*;
#(
    parameter int IMG_WIDTH = 640
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  vs_i,
    input  logic                  de_i,
    input  logic [7:0]            y_i,
    output logic [2:0][2:0][7:0]  taps_o,
    output logic                  border_o
);

    localparam int               COL_W   = $clog2(IMG_WIDTH + 1);
    localparam int               AW      = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH);

    logic [COL_W-1:0]     col_q, col_d;
    logic [1:0]           ln_q, ln_d;
    logic                 dePrev_q, vsPrev_q;
    logic                 inRange;
    logic [AW-1:0]        addr;
    logic [7:0]           lb0 [IMG_WIDTH];
    logic [7:0]           lb1 [IMG_WIDTH];
    logic [7:0]           rdTop_q, rdMid_q, cur_q;
    logic                 s1Valid_q, s1Border_q;
    logic [2:0][2:0][7:0] win_q;
    logic                 border_q;

    // Pixels past the buffer depth are neither stored nor read, so an
    // overlong line cannot wrap around and corrupt the start of the buffer.
    assign inRange = (col_q < COL_MAX);
    assign addr    = col_q[AW-1:0];

    // Column restarts every line; the line count saturates at 2, which is all
    // the border test needs. A frame start beats a coincident line end.
    always_comb begin
        col_d = col_q;
        ln_d  = ln_q;
        if (!de_i) begin
            col_d = '0;
        end else if (col_q != COL_MAX) begin
            col_d = col_q + COL_W'(1);
        end
        if (vs_i && !vsPrev_q) begin
            ln_d = '0;
        end else if (dePrev_q && !de_i && ln_q != 2'd2) begin
            ln_d = ln_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            col_q    <= '0;
            ln_q     <= '0;
            dePrev_q <= 1'b0;
            vsPrev_q <= 1'b0;
        end else begin
            col_q    <= col_d;
            ln_q     <= ln_d;
            dePrev_q <= de_i;
            vsPrev_q <= vs_i;
        end
    end

    // Read-before-write: LB1 inherits what LB0 held for this column, so the
    // pair always holds the two lines above the current one.
    always_ff @(posedge clk) begin
        if (de_i && inRange) begin
            lb0[addr] <= y_i;
            lb1[addr] <= lb0[addr];
        end
    end

    // Stage 1 capture. The border flag is decided here, while col and ln still
    // describe the pixel entering the window.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rdTop_q    <= '0;
            rdMid_q    <= '0;
            cur_q      <= '0;
            s1Valid_q  <= 1'b0;
            s1Border_q <= 1'b0;
        end else begin
            rdTop_q    <= inRange ? lb1[addr] : 8'd0;
            rdMid_q    <= inRange ? lb0[addr] : 8'd0;
            cur_q      <= y_i;
            s1Valid_q  <= de_i;
            s1Border_q <= !de_i || !inRange || (col_q < COL_W'(2)) || (ln_q < 2'd2);
        end
    end

    // Stage 2: the window only moves on valid pixels and empties in blanking.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            win_q    <= '0;
            border_q <= 1'b0;
        end else begin
            border_q <= s1Border_q;
            if (!s1Valid_q) begin
                win_q <= '0;
            end else begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= rdTop_q;
                win_q[1][2] <= rdMid_q;
                win_q[2][2] <= cur_q;
            end
        end
    end

    assign taps_o   = win_q;
    assign border_o = border_q;

endmodule

// File: rtl/luma_sobel_edge.sv
// Streaming 3x3 Sobel edge detector on 8-bit luma.
// Ports:
//   clk, rst_b               : pixel clock, asynchronous active-low reset
//   vs_in, hs_in, de_in, y_in: incoming syncs and luma
//   vs_out, hs_out, de_out   : syncs delayed by LAT clocks
//   y_out                    : |Gx|+|Gy| saturated to 8 bits, or 0/255 when
//                              THRESH is non-zero; 0 outside valid windows
// Output pixel (l,c) is the window centred on input (l-1,c-1).
module luma_sobel_edge
    import luma_sobel_edge_pkg::*;
#(
    parameter int IMG_WIDTH = 640,
    parameter int THRESH    = 0
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       vs_in,
    input  logic       hs_in,
    input  logic       de_in,
    input  logic [7:0] y_in,
    output logic       vs_out,
    output logic       hs_out,
    output logic       de_out,
    output logic [7:0] y_out
);

    localparam logic [MAG_W-1:0] THRESH_V = MAG_W'(THRESH);

    logic [2:0][2:0][7:0]    taps;
    logic                    border;
    logic                    unusedCentre;
    logic [9:0]              gxPos, gxNeg, gyPos, gyNeg;
    logic signed [MAG_W-1:0] gx_d, gy_d, gx_q, gy_q;
    logic                    border3_q;
    logic [MAG_W-1:0]        mag;
    logic [7:0]              yVal, y_d, y_q;
    logic [LAT-1:0]          vsDly_q, hsDly_q, deDly_q;

    sobel_line_window #(
        .IMG_WIDTH(IMG_WIDTH)
    ) u_window (
        .clk      (clk),
        .rst_b    (rst_b),
        .vs_i     (vs_in),
        .de_i     (de_in),
        .y_i      (y_in),
        .taps_o   (taps),
        .border_o (border)
    );

    // The centre tap carries zero weight in both kernels.
    assign unusedCentre = ^taps[1][1];

    // Weighted column/row sums are at most 1020, so 10 bits each suffice and
    // their difference fits an 11-bit signed value.
    always_comb begin
        gxPos = {2'b00, taps[0][2]} + {1'b0, taps[1][2], 1'b0} + {2'b00, taps[2][2]};
        gxNeg = {2'b00, taps[0][0]} + {1'b0, taps[1][0], 1'b0} + {2'b00, taps[2][0]};
        gyPos = {2'b00, taps[2][0]} + {1'b0, taps[2][1], 1'b0} + {2'b00, taps[2][2]};
        gyNeg = {2'b00, taps[0][0]} + {1'b0, taps[0][1], 1'b0} + {2'b00, taps[0][2]};
        gx_d  = $signed({1'b0, gxPos}) - $signed({1'b0, gxNeg});
        gy_d  = $signed({1'b0, gyPos}) - $signed({1'b0, gyNeg});
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            gx_q      <= '0;
            gy_q      <= '0;
            border3_q <= 1'b0;
        end else begin
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            border3_q <= border;
        end
    end

    // The border flag already covers blanking, so y_out is 0 whenever de_out is.
    always_comb begin
        mag = absMag(gx_q) + absMag(gy_q);
        if (THRESH != 0) begin
            yVal = (mag >= THRESH_V) ? SAT_MAX : 8'd0;
        end else begin
            yVal = sat8(mag);
        end
        y_d = border3_q ? 8'd0 : yVal;
    end

    // Output register plus sync delay lines matching the data pipeline depth.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            y_q     <= '0;
            vsDly_q <= '0;
            hsDly_q <= '0;
            deDly_q <= '0;
        end else begin
            y_q     <= y_d;
            vsDly_q <= {vsDly_q[LAT-2:0], vs_in};
            hsDly_q <= {hsDly_q[LAT-2:0], hs_in};
            deDly_q <= {deDly_q[LAT-2:0], de_in};
        end
    end

    assign y_out  = y_q;
    assign vs_out = vsDly_q[LAT-1];
    assign hs_out = hsDly_q[LAT-1];
    assign de_out = deDly_q[LAT-1];

endmodule

// File: tb/tb_luma_sobel_edge.sv
// Bench for luma_sobel_edge: three instances (raw, THRESH=32, THRESH=64) share
// one input stream and are checked against a frame-level Sobel model.
module tb_luma_sobel_edge;

    localparam int W = 16;

    logic       clk   = 1'b0;
    logic       rst_b = 1'b1;
    logic       vs_in = 1'b0;
    logic       hs_in = 1'b0;
    logic       de_in = 1'b0;
    logic [7:0] y_in  = 8'd0;
    logic [2:0] vsO, hsO, deO;
    logic [7:0] yRaw, yT32, yT64;

    always #5 clk = ~clk;

    luma_sobel_edge #(.IMG_WIDTH(W), .THRESH(0)) u_raw (
        .clk(clk), .rst_b(rst_b), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in), .y_in(y_in),
        .vs_out(vsO[0]), .hs_out(hsO[0]), .de_out(deO[0]), .y_out(yRaw));
    luma_sobel_edge #(.IMG_WIDTH(W), .THRESH(32)) u_t32 (
        .clk(clk), .rst_b(rst_b), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in), .y_in(y_in),
        .vs_out(vsO[1]), .hs_out(hsO[1]), .de_out(deO[1]), .y_out(yT32));
    luma_sobel_edge #(.IMG_WIDTH(W), .THRESH(64)) u_t64 (
        .clk(clk), .rst_b(rst_b), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in), .y_in(y_in),
        .vs_out(vsO[2]), .hs_out(hsO[2]), .de_out(deO[2]), .y_out(yT64));

    typedef struct packed {
        logic [2:0] vs;
        logic [2:0] hs;
        logic [2:0] de;
        logic [7:0] y0;
        logic [7:0] y32;
        logic [7:0] y64;
    } outs_t;

    outs_t pipeQ[$];
    outs_t expQ[$];
    outs_t obsQ[$];
    int    vectors = 0;
    int    miscompares = 0;

    // Model state: line/column position and the two stored lines.
    int         mCol, mLn;
    bit         mDePrev, mVsPrev;
    logic [7:0] lb0 [W];
    logic [7:0] lb1 [W];
    logic [7:0] rowTop [W];
    logic [7:0] rowMid [W];
    logic [7:0] rowCur [W];

    function automatic outs_t observed();
        outs_t o;
        o.vs = vsO; o.hs = hsO; o.de = deO;
        o.y0 = yRaw; o.y32 = yT32; o.y64 = yT64;
        return o;
    endfunction

    // One input pixel through the spec rules; yields the output it should produce.
    task automatic modelStep(input logic vs, input logic hs, input logic de,
                             input logic [7:0] y, output outs_t e);
        int c, gx, gy, mag;
        e = '0;
        e.vs = {3{vs}}; e.hs = {3{hs}}; e.de = {3{de}};
        c = mCol;
        if (de && c < W) begin
            rowTop[c] = lb1[c];
            rowMid[c] = lb0[c];
            rowCur[c] = y;
            lb1[c] = lb0[c];
            lb0[c] = y;
            if (c >= 2 && mLn >= 2) begin
                gx = (int'(rowTop[c]) + 2 * int'(rowMid[c]) + int'(rowCur[c]))
                   - (int'(rowTop[c-2]) + 2 * int'(rowMid[c-2]) + int'(rowCur[c-2]));
                gy = (int'(rowCur[c-2]) + 2 * int'(rowCur[c-1]) + int'(rowCur[c]))
                   - (int'(rowTop[c-2]) + 2 * int'(rowTop[c-1]) + int'(rowTop[c]));
                mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                e.y0  = (mag > 255) ? 8'd255 : 8'(mag);
                e.y32 = (mag >= 32) ? 8'd255 : 8'd0;
                e.y64 = (mag >= 64) ? 8'd255 : 8'd0;
            end
        end
        if (de) mCol = (mCol < W) ? mCol + 1 : W;
        else    mCol = 0;
        if (vs && !mVsPrev)      mLn = 0;
        else if (mDePrev && !de) mLn = mLn + 1;
        mDePrev = de;
        mVsPrev = vs;
    endtask

    task automatic step(input logic vs, input logic hs, input logic de, input logic [7:0] y);
        outs_t e;
        vs_in = vs; hs_in = hs; de_in = de; y_in = y;
        modelStep(vs, hs, de, y, e);
        pipeQ.push_back(e);
        @(posedge clk);
        #1;
        expQ.push_back(pipeQ.pop_front());
        obsQ.push_back(observed());
    endtask

    task automatic doReset(input int n);
        rst_b = 1'b0;
        vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0; y_in = 8'd0;
        #1;
        expQ.push_back('0);
        obsQ.push_back(observed());
        repeat (n) begin
            @(posedge clk);
            #1;
            expQ.push_back('0);
            obsQ.push_back(observed());
        end
        mCol = 0; mLn = 0; mDePrev = 1'b0; mVsPrev = 1'b0;
        pipeQ.delete();
        repeat (LATM1) pipeQ.push_back('0);
        rst_b = 1'b1;
    endtask

    localparam int LATM1 = 3;

    function automatic logic [7:0] pixel(input int kind, input int c);
        case (kind)
            0:       return 8'd100;
            1:       return (c < 8) ? 8'd0 : 8'd10;
            2:       return (c < 8) ? 8'd0 : 8'd200;
            default: return ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255))
                                                        : 8'(60 + $urandom_range(0, 20));
        endcase
    endfunction

    task automatic sendLine(input int kind, input int width, input int blank);
        for (int b = 0; b < blank; b++) step(1'b0, b == 0, 1'b0, 8'd0);
        for (int c = 0; c < width; c++) step(1'b0, 1'b0, 1'b1, pixel(kind, c));
    endtask

    task automatic sendFrame(input int kind, input int lines, input int width, input int blank);
        step(1'b1, 1'b0, 1'b0, 8'd0);
        for (int l = 0; l < lines; l++) sendLine(kind, width, blank);
    endtask

    task automatic flush(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_reset();
        outs_t e, o;
        #2;
        doReset(4);
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL reset vec %0d: got %h expected %h", vectors, o, e);
            end
        end
    endtask

    task automatic test_flat();
        outs_t e, o;
        int deCount;
        deCount = 0;
        sendFrame(0, 8, W, 3);
        flush(6);
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); vectors++;
            if (o.de == 3'b111) deCount++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL flat vec %0d: got %h expected %h", vectors, o, e);
            end
        end
        vectors++;
        if (deCount !== 16 * 8) begin
            miscompares++;
            $display("[TB] FAIL flat_de_count: got %0d expected %0d", deCount, 16 * 8);
        end
    endtask

    task automatic test_vertical_step();
        outs_t e, o;
        int hit40, hit32, hit64;
        hit40 = 0; hit32 = 0; hit64 = 0;
        sendFrame(1, 8, W, 3);
        flush(6);
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); vectors++;
            if (o.y0 == 8'd40) hit40++;
            if (o.y32 == 8'd255) hit32++;
            if (o.y64 != 8'd0) hit64++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL vstep vec %0d: got %h expected %h", vectors, o, e);
            end
        end
        vectors++;
        if (hit40 !== 12) begin
            miscompares++;
            $display("[TB] FAIL vstep_raw40_count: got %0d expected 12", hit40);
        end
        vectors++;
        if (hit32 !== 12) begin
            miscompares++;
            $display("[TB] FAIL vstep_t32_count: got %0d expected 12", hit32);
        end
        vectors++;
        if (hit64 !== 0) begin
            miscompares++;
            $display("[TB] FAIL vstep_t64_count: got %0d expected 0", hit64);
        end
    endtask

    task automatic test_saturate();
        outs_t e, o;
        int hit;
        hit = 0;
        sendFrame(2, 8, W, 3);
        flush(6);
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); vectors++;
            if (o.y0 == 8'd255) hit++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL saturate vec %0d: got %h expected %h", vectors, o, e);
            end
        end
        vectors++;
        if (hit !== 12) begin
            miscompares++;
            $display("[TB] FAIL saturate_count: got %0d expected 12", hit);
        end
    endtask

    task automatic test_overlong();
        outs_t e, o;
        sendFrame(3, 6, 20, 3);
        sendFrame(3, 4, W, 2);
        flush(6);
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL overlong vec %0d: got %h expected %h", vectors, o, e);
            end
        end
    endtask

    // Frames follow each other with no trailing blank, so every frame start
    // coincides with the previous line's de falling edge.
    task automatic test_back_to_back();
        outs_t e, o;
        for (int f = 0; f < 3; f++) begin
            sendFrame(3, $urandom_range(4, 6), $urandom_range(6, W), (f == 2) ? 2 : 1);
        end
        flush(6);
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL back_to_back vec %0d: got %h expected %h", vectors, o, e);
            end
        end
    endtask

    task automatic test_reset_midframe();
        outs_t e, o;
        int nz;
        nz = 0;
        sendFrame(3, 4, W, 3);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 1'b1, pixel(3, c));
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL midframe_pre vec %0d: got %h expected %h", vectors, o, e);
            end
        end
        doReset(3);
        flush(11);
        for (int l = 5; l < 10; l++) sendLine(3, W, 3);
        flush(6);
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); vectors++;
            if (o.y0 != 8'd0) nz++;
            if (o !== e) begin
                miscompares++;
                $display("[TB] FAIL midframe_post vec %0d: got %h expected %h", vectors, o, e);
            end
        end
        vectors++;
        if (nz == 0) begin
            miscompares++;
            $display("[TB] FAIL midframe_edges_return: got %0d nonzero outputs expected more than 0", nz);
        end
    endtask

    initial begin
        mCol = 0; mLn = 0; mDePrev = 1'b0; mVsPrev = 1'b0;
        for (int i = 0; i < W; i++) begin
            lb0[i] = 8'd0; lb1[i] = 8'd0;
            rowTop[i] = 8'd0; rowMid[i] = 8'd0; rowCur[i] = 8'd0;
        end
        test_reset();
        test_flat();
        test_vertical_step();
        test_saturate();
        test_overlong();
        test_back_to_back();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/luma_sobel_edge.md
# luma_sobel_edge

Streaming 3x3 Sobel edge detector on the 8-bit luma stream produced by the RGB-to-YCbCr stage. It consumes vs/hs/de plus Y at one pixel per clock, buffers two previous lines, computes the saturated gradient magnitude |Gx|+|Gy|, and optionally binarises it. It emits a sync-aligned stream with fixed latency, feeding the image writer or any later stage.

## Interface
- IMG_WIDTH, 640: maximum active pixels per line; this is the line-buffer depth.
- THRESH, 0: binarisation threshold; 0 outputs the raw magnitude.
- clk  in  1  pixel clock.
- rst_b  in  1  reset, asynchronous, active-low.
- vs_in  in  1  vertical sync, active-high.
- hs_in  in  1  horizontal sync, passed through only.
- de_in  in  1  data enable, high during active pixels.
- y_in  in  8  luma, unsigned.
- vs_out  out  1  vs_in delayed by LAT.
- hs_out  out  1  hs_in delayed by LAT.
- de_out  out  1  de_in delayed by LAT.
- y_out  out  8  edge value. Reads 0 whenever de_out is 0.

## Operation
- **Column counter col:** 0..IMG_WIDTH-1.
  - Increments on each de_in=1 cycle.
  - Clears whenever de_in=0.
  - Saturates at IMG_WIDTH; pixels at col≥IMG_WIDTH are not written and output 0.
- **Line counter ln:** 0..2, saturating.
  - Increments on the de_in falling edge.
  - Clears on the vs_in rising edge.
- **Line buffers:** two RAMs, LB0 holds the previous line and LB1 the line before it.
  - On each de_in=1 cycle at address col: LB0 is read and written with y_in, and LB1 is written with the old LB0 data.
  - RAMs are not reset.
- **Window:** 3x3 shift registers, row r0 oldest to r2 current, columns c0 oldest to c2 newest.
  - Shifts only when de_in=1.
  - Is cleared when de_in=0.
- **Gradients:**
  - Gx = (p[0][2]+2p[1][2]+p[2][2]) − (p[0][0]+2p[1][0]+p[2][0]).
  - Gy = (p[2][0]+2p[2][1]+p[2][2]) − (p[0][0]+2p[0][1]+p[0][2]).
  - Both are 11-bit signed, range ±1020.
  - mag = |Gx|+|Gy|, 11-bit unsigned, maximum 2040. Values above 255 saturate to 255.
- **Binarise:** if THRESH≠0, y_out = (mag≥THRESH) ? 255 : 0.
- **Border:** y_out=0 when ln<2 or col<2 at window-input time. Line 0/1 and column 0/1 outputs are always 0.
- **Spatial offset:** output pixel (l,c) is the window centred on input (l−1,c−1). This one-line, one-pixel shift is intentional.

## Timing
- LAT = 4 clocks for syncs and data, constant:
  - S1: col/ln update, RAM read/write.
  - S2: window shift.
  - S3: Gx, Gy.
  - S4: abs, sum, saturate, threshold, output register.
- Sync delay uses 4-deep shift registers, one each for vs, hs and de.
- **Reset values:** vs_out=0, hs_out=0, de_out=0, y_out=0. col, ln, window and pipeline registers all reset to 0.
- **Reset mid-frame:** ln restarts at 0. The first two completed lines after reset output 0, so stale RAM contents are never visible.
- **Simultaneous de falling edge and vs rising edge:** the clear wins, ln=0.
- **Lines longer than IMG_WIDTH:** the excess is output as 0 with no RAM wrap. Shorter lines are fine because col restarts each line.
- **Back-to-back lines with a 1-cycle de gap:** supported.

## Structure
- Shared package holds:
  - LAT=4.
  - MAG_W=11.
  - Saturation constant 8'd255.
  - An abs/saturate function.
- Sub-module sobel_line_window:
  - Owns col, ln, both RAMs and the 3x3 window.
  - Outputs nine taps plus a border flag.
- Top-level luma_sobel_edge holds the gradient arithmetic, threshold logic and sync delay line.

## Test plan
- **Flat field:** Y=100 on a 16x8 frame -> every y_out=0 and de_out matches de_in delayed by exactly 4 clocks.
- **Vertical step, THRESH=0:** Y=0 for col<8, Y=10 for col≥8 -> y_out=40 at output cols 8 and 9 on lines ≥2, 0 elsewhere.
- **Step 0|200, THRESH=0:** Gx=800 -> y_out=255 (saturated) at cols 8 and 9.
- **Binarise:** step 0|10 with THRESH=32 -> 255 at cols 8 and 9. The same step with THRESH=64 -> 0 everywhere.
- **Overlong line, IMG_WIDTH=16:** 20-pixel lines -> y_out=0 for cols 16..19, and the next line's outputs are unaffected.
- **Reset mid-frame:** assert rst_b=0 for 3 clocks during line 4 -> all outputs 0 during reset. After release, output lines 0 and 1 are 0 and edges reappear from line 2.
